reg_file_n: RTL and testbench
=============================

REG_FILE_N -- requirements
Module: reg_file_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of registers.
REQ-003 The block SHALL have parameter ADDR_W, default 5, address width, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: clr, input, 1, reset, synchronous and active-high.
REQ-007 Port: we, input, 1, write enable.
REQ-008 Port: waddr, input, ADDR_W, write address.
REQ-009 Port: wdata, input, WIDTH, write data.
REQ-010 Port: raddr_a, input, ADDR_W, read port A address.
REQ-011 Port: raddr_b, input, ADDR_W, read port B address.
REQ-012 Port: oe_a, input, 1, port A output enable.
REQ-013 Port: oe_b, input, 1, port B output enable.
REQ-014 Port: rdata_a, output, WIDTH, tri-state read data A.
REQ-015 Port: rdata_b, output, WIDTH, tri-state read data B.

Function
REQ-016 The block SHALL hold DEPTH registers of WIDTH bits each.
REQ-017 The block SHALL load wdata into register waddr on a rising clk edge when we=1 and clr=0.
REQ-018 The block SHALL hold every register not addressed by a qualifying write.
REQ-019 The block SHALL ignore writes to waddr >= DEPTH.
REQ-020 When ZERO_REG=1, the block SHALL ignore writes to address 0, and reads of address 0 SHALL return 0.
REQ-021 The read ports SHALL be combinational, with zero cycles from raddr change to rdata.
REQ-022 A read of an address >= DEPTH SHALL return all zeros.
REQ-023 rdata_a SHALL be high-Z on all bits when oe_a=0; rdata_b likewise with oe_b.
REQ-024 The block SHALL let both read ports address the same register simultaneously, each returning identical data.
REQ-025 Without bypass, a write SHALL become visible on the read ports in the cycle after the write edge.
REQ-026 Output enables SHALL affect only the drivers and never register contents.

Reset
REQ-027 On a rising clk edge with clr=1, the block SHALL clear all registers to 0.
REQ-028 clr SHALL take priority over a simultaneous we; the write is discarded.
REQ-029 Read ports SHALL return 0 for every in-range address in the cycle after reset, subject to oe.
REQ-030 Reset SHALL NOT alter tri-state behaviour; an output with oe=0 stays high-Z during and after reset.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL, when defined, forward wdata combinationally to any read port whose raddr equals waddr while we=1, clr=0, waddr is in range, and waddr is not 0 with ZERO_REG=1.
REQ-032 When REGFILE_BYPASS_EN is undefined, read ports SHALL return the stored value only, which is the pre-write value during the write cycle.

Verification
REQ-033 Reset: clr=1 for one edge after arbitrary writes, then read all addresses with oe_a=oe_b=1 -> all 0.
REQ-034 Write/read: we=1, waddr=5, wdata=0xDEADBEEF, then next cycle raddr_a=5 and raddr_b=5 -> both 0xDEADBEEF.
REQ-035 Zero reg: ZERO_REG=1, write 0x12345678 to addr 0 -> read addr 0 returns 0x00000000.
REQ-036 Priority: clr=1 and we=1 with waddr=3, wdata=0xFFFFFFFF on the same edge -> addr 3 reads 0.
REQ-037 Tri-state: oe_a=0, oe_b=1, raddr_b=5 holding 0xDEADBEEF -> rdata_a all Z, rdata_b 0xDEADBEEF.
REQ-038 Bypass: addr 7 holds 0x1, and in the same cycle we=1, waddr=7, wdata=0x2, raddr_a=7 -> rdata_a=0x2 with REGFILE_BYPASS_EN, 0x1 without.

Source files
------------

// File: rtl/reg_file_n.sv
// Multi-port register file: one synchronous write port, two combinational tri-state read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_n #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              oe_a,
    input  logic              oe_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // A write qualifies only when in range and not aimed at a hardwired zero register.
    assign wr_ok = we && ({1'b0, waddr} < DEPTH_L) && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_a = '0;
        if (({1'b0, raddr_a} < DEPTH_L) && !((ZERO_REG != 0) && (raddr_a == '0))) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && !clr && (raddr_a == waddr)) begin
                rd_a = wdata;
            end else begin
                rd_a = regs[raddr_a];
            end
`else
            rd_a = regs[raddr_a];
`endif
        end
    end

    always_comb begin
        rd_b = '0;
        if (({1'b0, raddr_b} < DEPTH_L) && !((ZERO_REG != 0) && (raddr_b == '0))) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && !clr && (raddr_b == waddr)) begin
                rd_b = wdata;
            end else begin
                rd_b = regs[raddr_b];
            end
`else
            rd_b = regs[raddr_b];
`endif
        end
    end

    assign rdata_a = oe_a ? rd_a : {WIDTH{1'bz}};
    assign rdata_b = oe_b ? rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_file_n.sv
// Scoreboard bench for reg_file_n: directed scenarios plus randomized traffic checked
// against an array-based reference model.
module tb_reg_file_n;

    localparam int W     = 32;
    localparam int DEPTH = 24;
    localparam int AW    = 5;
    localparam int ZR    = 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [AW-1:0] raddr_a = '0;
    logic [AW-1:0] raddr_b = '0;
    logic          oe_a = 1'b0;
    logic          oe_b = 1'b0;
    wire  [W-1:0]  rdata_a;
    wire  [W-1:0]  rdata_b;

    reg_file_n #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .oe_a(oe_a), .oe_b(oe_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        string        nm;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [DEPTH];
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] expect_read(input int addr, input logic oe);
        logic [W-1:0] zv;
        zv = {W{1'bz}};
        if (!oe) return zv;
        if (addr >= DEPTH) return '0;
        if (ZR != 0 && addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && !clr && int'(waddr) == addr && !(ZR != 0 && addr == 0)) return wdata;
`endif
        return model[addr];
    endfunction

    // Apply inputs for one cycle, queue the expected reads, then advance the model past the edge.
    task automatic step(input logic c, input logic w, input int wa, input logic [W-1:0] wd,
                        input int ra, input int rb, input logic oa, input logic ob,
                        input string nm, input bit chk);
        exp_t e;
        clr = c; we = w; waddr = AW'(wa); wdata = wd;
        raddr_a = AW'(ra); raddr_b = AW'(rb); oe_a = oa; oe_b = ob;
        if (chk) begin
            e.a = expect_read(ra, oa);
            e.b = expect_read(rb, ob);
            e.nm = nm;
            sb.push_back(e);
        end
        if (c) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w && wa < DEPTH && !(ZR != 0 && wa == 0)) begin
            model[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rdata_a !== e.a) begin
                errors++;
                $display("FAIL %s port_a: got %h expected %h", e.nm, rdata_a, e.b === e.b ? e.a : e.a);
            end
            checks++;
            if (rdata_b !== e.b) begin
                errors++;
                $display("FAIL %s port_b: got %h expected %h", e.nm, rdata_b, e.b);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        // Initial reset: register contents are unknown before it, so nothing is checked yet.
        step(1, 0, 0, '0, 0, 0, 1, 1, "init", 0);

        for (int i = 0; i < 32; i += 2) step(0, 0, 0, '0, i, i + 1, 1, 1, "post_init", 1);

        // Arbitrary writes, including out-of-range and address 0.
        for (int i = 0; i < 32; i++) step(0, 1, i, $urandom, i, (i + 5) % 32, 1, 1, "fill", 1);
        step(1, 0, 0, '0, 3, 4, 1, 1, "reset_edge", 1);
        for (int i = 0; i < 32; i += 2) step(0, 0, 0, '0, i, i + 1, 1, 1, "after_reset", 1);

        step(0, 1, 5, 32'hDEADBEEF, 5, 5, 1, 1, "wr5_same_cycle", 1);
        step(0, 0, 0, '0, 5, 5, 1, 1, "rd5", 1);

        step(0, 1, 0, 32'h12345678, 0, 1, 1, 1, "wr_zero", 1);
        step(0, 0, 0, '0, 0, 0, 1, 1, "rd_zero", 1);

        step(0, 1, 3, 32'hA5A5A5A5, 3, 3, 1, 1, "wr3", 1);
        step(1, 1, 3, 32'hFFFFFFFF, 3, 5, 1, 1, "clr_vs_we", 1);
        step(0, 0, 0, '0, 3, 5, 1, 1, "rd3_after_clr", 1);

        step(0, 1, 5, 32'hDEADBEEF, 5, 5, 1, 1, "rewr5", 1);
        step(0, 0, 0, '0, 5, 5, 0, 1, "tristate_a", 1);
        step(0, 0, 0, '0, 5, 5, 1, 0, "tristate_b", 1);
        step(1, 0, 0, '0, 5, 5, 0, 1, "tristate_in_clr", 1);
        step(0, 0, 0, '0, 5, 5, 0, 1, "tristate_after_clr", 1);

        step(0, 1, 7, 32'h1, 7, 7, 1, 1, "wr7_1", 1);
        step(0, 1, 7, 32'h2, 7, 9, 1, 1, "bypass7", 1);
        step(0, 0, 0, '0, 7, 7, 1, 1, "rd7_2", 1);

        step(0, 1, 20, 32'hCAFEF00D, 20, 20, 1, 1, "wr_oor_setup", 1);
        step(0, 1, 25, 32'h0BADF00D, 25, 20, 1, 1, "wr_oor", 1);
        step(0, 0, 0, '0, 25, 30, 1, 1, "rd_oor", 1);
        step(0, 1, 23, 32'h13579BDF, 23, 24, 1, 1, "wr_last", 1);
        step(0, 0, 0, '0, 23, 20, 1, 1, "rd_last", 1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 31),
                 $urandom, $urandom_range(0, 31), $urandom_range(0, 31),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), "random", 1);
        end

        we = 0; clr = 0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
